// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Streaming RISC-V instruction encoder / instruction-memory loader. Accepts
// decoded instruction fields over a valid/ready handshake, assembles an
// R/I/S-format 32-bit word (immediate bits scattered exactly as the immediate
// extender gathers them) and writes it into instruction memory at
// consecutive word addresses starting at BASE_ADDR.
//
// Optional feature macro: INSTR_ENCODER_RANGECHECK_EN
//   defined   : I/S requests whose i_imm does not fit in 12 signed bits are
//               rejected like illegal opcodes (o_error set, no write).
//   undefined : i_imm is truncated to imm[11:0].
//
// Parameters:
//   DEPTH      instruction-memory capacity in words (power of two, >= 2)
//   BASE_ADDR  byte address of word 0
//
// Ports:
//   i_clk         clock, all state updates on the rising edge
//   i_resetN      synchronous active-low reset
//   i_valid       request valid
//   o_ready       encoder can accept a request this cycle
//   i_opcode      instruction opcode (selects R/I/S format)
//   i_rd/i_rs1/i_rs2, i_funct3, i_funct7, i_imm   instruction fields
//   i_clear       restart loading at word 0 and clear the error flag
//   o_imemWrEn    one-cycle instruction-memory write strobe
//   o_imemAddr    write byte address, BASE_ADDR + 4*index (mod 2^32)
//   o_imemWrData  encoded instruction word
//   o_count       words written since reset/clear
//   o_full        DEPTH words written; requests stall until i_clear
//   o_error       sticky: a rejected request has been seen
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                     i_clk,
    input  logic                     i_resetN,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [6:0]               i_opcode,
    input  logic [4:0]               i_rd,
    input  logic [4:0]               i_rs1,
    input  logic [4:0]               i_rs2,
    input  logic [2:0]               i_funct3,
    input  logic [6:0]               i_funct7,
    input  logic [31:0]              i_imm,
    input  logic                     i_clear,
    output logic                     o_imemWrEn,
    output logic [31:0]              o_imemAddr,
    output logic [31:0]              o_imemWrData,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_error
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FULL
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_wrEn;
    logic [31:0]     r_word;
    logic [IW-1:0]   r_index;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_error;

    logic            w_isI;
    logic            w_isS;
    logic            w_isR;
    logic            w_immOk;
    logic            w_legal;
    logic [31:0]     w_word;
    logic [CW-1:0]   w_countNext;

    // ---------------------------------------------------------------
    // Format decode and word assembly
    // ---------------------------------------------------------------
    always_comb begin
        w_isI = (i_opcode == OP_LOAD) || (i_opcode == OP_IMM) ||
                (i_opcode == OP_JALR);
        w_isS = (i_opcode == OP_STORE);
        w_isR = (i_opcode == OP_REG);
    end

`ifdef INSTR_ENCODER_RANGECHECK_EN
    // Fits in 12 signed bits when bits 31..11 are a pure sign extension.
    assign w_immOk = (i_imm[31:11] == {21{i_imm[11]}});
`else
    logic w_unused_imm;
    assign w_unused_imm = ^i_imm[31:12];
    assign w_immOk      = 1'b1;
`endif

    // R-type ignores the immediate, so the range check only gates I/S.
    assign w_legal = w_isR || ((w_isI || w_isS) && w_immOk);

    always_comb begin
        w_word = '0;
        if (w_isI) begin
            w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        end else if (w_isS) begin
            w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        end else if (w_isR) begin
            w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        end
    end

    assign w_countNext = r_count + CW'(1);

    // ---------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_wrEn  <= 1'b0;
            r_word  <= '0;
            r_index <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_error <= 1'b0;
        end else if (i_clear) begin
            // A WRITE cycle overlapping the clear has already driven its
            // strobe; only the index/count update is discarded here.
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_wrEn  <= 1'b0;
            r_index <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (i_valid && r_ready) begin
                        if (w_legal) begin
                            r_word  <= w_word;
                            r_wrEn  <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= WRITE;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    r_wrEn  <= 1'b0;
                    // DEPTH is a power of two, so the index wraps to 0
                    // exactly when the memory becomes full.
                    r_index <= r_index + IW'(1);
                    r_count <= w_countNext;
                    if (w_countNext == CW'(DEPTH)) begin
                        r_full  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= FULL;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                FULL: begin
                    r_ready <= 1'b0;
                    r_wrEn  <= 1'b0;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_wrEn  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_imemWrEn   = r_wrEn;
    assign o_imemAddr   = BASE_ADDR + (32'(r_index) << 2);
    assign o_imemWrData = r_word;
    assign o_count      = r_count;
    assign o_full       = r_full;
    assign o_error      = r_error;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] BASE_ADDR = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        resetN;
    logic        valid;
    logic        ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        clear;
    logic        wrEn;
    logic [31:0] addr;
    logic [31:0] wrData;
    logic [2:0]  count;
    logic        full;
    logic        error;

    int checks   = 0;
    int failures = 0;

    int m_count  = 0;
    bit m_error  = 1'b0;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          exp_ok;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [5];

    instr_encoder #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .i_clk       (clk),
        .i_resetN    (resetN),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_opcode    (opcode),
        .i_rd        (rd),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .i_funct3    (funct3),
        .i_funct7    (funct7),
        .i_imm       (imm),
        .i_clear     (clear),
        .o_imemWrEn  (wrEn),
        .o_imemAddr  (addr),
        .o_imemWrData(wrData),
        .o_count     (count),
        .o_full      (full),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference encoder: built from the field layout rules with plain arithmetic.
    function automatic void model_enc(input vec_t v, output bit ok, output logic [31:0] w);
        bit isI, isS, isR, inRange;
        int simm;
        int unsigned imm12;
        simm    = int'($signed(v.imm));
        isI     = (v.op == 7'h03) || (v.op == 7'h13) || (v.op == 7'h67);
        isS     = (v.op == 7'h23);
        isR     = (v.op == 7'h33);
        inRange = (simm >= -2048) && (simm <= 2047);
        ok      = isI || isS || isR;
`ifdef INSTR_ENCODER_RANGECHECK_EN
        if ((isI || isS) && !inRange) ok = 1'b0;
`else
        if (inRange) ok = ok;
`endif
        imm12 = int'(v.imm) & 32'hFFF;
        w = '0;
        if (isI)
            w = (32'(imm12) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) |
                (32'(v.rd) << 7) | 32'(v.op);
        else if (isS)
            w = (32'(imm12 / 32) << 25) | (32'(v.rs2) << 20) | (32'(v.rs1) << 15) |
                (32'(v.f3) << 12) | (32'(imm12 % 32) << 7) | 32'(v.op);
        else if (isR)
            w = (32'(v.f7) << 25) | (32'(v.rs2) << 20) | (32'(v.rs1) << 15) |
                (32'(v.f3) << 12) | (32'(v.rd) << 7) | 32'(v.op);
    endfunction

    function automatic logic [31:0] exp_addr(input int idx);
        logic [31:0] a;
        a = BASE_ADDR + 32'(idx * 4);
        return a;
    endfunction

    task automatic set_fields(input vec_t v);
        opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    // Called at a negedge; returns at a negedge after the outcome is checked.
    task automatic do_req(input vec_t v);
        int n;
        set_fields(v);
        valid = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%b required=1", ready);
            valid = 1'b0;
            return;
        end
        @(negedge clk);
        valid = 1'b0;
        if (v.exp_ok) begin
            chk("wr_strobe", 32'(wrEn), 32'd1);
            chk("wr_addr", addr, exp_addr(m_count));
            chk("wr_data", wrData, v.exp_data);
            chk("ready_in_write", 32'(ready), 32'd0);
            m_count++;
            @(negedge clk);
            chk("strobe_one_cycle", 32'(wrEn), 32'd0);
            chk("count_after_write", 32'(count), 32'(m_count));
            chk("full_after_write", 32'(full), 32'(m_count == DEPTH));
            chk("ready_after_write", 32'(ready), 32'(m_count != DEPTH));
        end else begin
            m_error = 1'b1;
            chk("reject_no_strobe", 32'(wrEn), 32'd0);
            chk("reject_error", 32'(error), 32'(m_error));
            chk("reject_count", 32'(count), 32'(m_count));
            chk("reject_ready", 32'(ready), 32'd1);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0;
        m_error = 1'b0;
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_full", 32'(full), 32'd0);
        chk("clear_error", 32'(error), 32'd0);
        chk("clear_ready", 32'(ready), 32'd1);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        int unsigned sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0: v.op = 7'h03;
            1: v.op = 7'h13;
            2: v.op = 7'h67;
            3: v.op = 7'h23;
            4: v.op = 7'h33;
            default: v.op = 7'($urandom);
        endcase
        v.rd  = 5'($urandom);
        v.rs1 = 5'($urandom);
        v.rs2 = 5'($urandom);
        v.f3  = 3'($urandom);
        v.f7  = 7'($urandom);
        if ($urandom_range(0, 2) != 0)
            v.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        else
            v.imm = $urandom;
        model_enc(v, v.exp_ok, v.exp_data);
        return v;
    endfunction

    initial begin
        vec_t v;

        resetN = 1'b0; valid = 1'b0; clear = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; imm = '0;

        tbl[0] = '{7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFFC1_2283};
        tbl[1] = '{7'h23, 5'd0, 5'd9, 5'd6, 3'd2, 7'd0, 32'd8,         1'b1, 32'h0064_A423};
        tbl[2] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         1'b1, 32'h0020_81B3};
        tbl[3] = '{7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,         1'b0, 32'h0};
`ifdef INSTR_ENCODER_RANGECHECK_EN
        tbl[4] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      1'b0, 32'h0};
`else
        tbl[4] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      1'b1, 32'h0000_0093};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_wren", 32'(wrEn), 32'd0);
        chk("rst_addr", addr, BASE_ADDR);
        chk("rst_data", wrData, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 5; i++) do_req(tbl[i]);

        // Top up to full (only needed when the range check rejected a vector)
        while (m_count < DEPTH) begin
            v = '{7'h13, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0};
            model_enc(v, v.exp_ok, v.exp_data);
            do_req(v);
        end

        // Full: requests stall
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(ready), 32'd0);
        set_fields(tbl[0]);
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_no_strobe", 32'(wrEn), 32'd0);
        end
        chk("stall_count", 32'(count), 32'(DEPTH));
        do_clear();

        // Clear together with valid in IDLE: not accepted
        set_fields(tbl[0]);
        valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        clear = 1'b0;
        chk("clrvalid_no_strobe", 32'(wrEn), 32'd0);
        chk("clrvalid_count", 32'(count), 32'd0);
        chk("clrvalid_ready", 32'(ready), 32'd1);

        // First write after clear lands at BASE_ADDR
        do_req(tbl[2]);

        // Clear during WRITE: strobe kept, no increment
        set_fields(tbl[1]);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("clrwr_strobe", 32'(wrEn), 32'd1);
        chk("clrwr_addr", addr, exp_addr(1));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0;
        m_error = 1'b0;
        chk("clrwr_no_strobe", 32'(wrEn), 32'd0);
        chk("clrwr_count", 32'(count), 32'd0);

        // Reset during WRITE, with error set beforehand
        do_req(tbl[3]);
        set_fields(tbl[0]);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("rstwr_strobe", 32'(wrEn), 32'd1);
        resetN = 1'b0;
        @(negedge clk);
        chk("rstwr_no_strobe", 32'(wrEn), 32'd0);
        chk("rstwr_ready", 32'(ready), 32'd0);
        chk("rstwr_addr", addr, BASE_ADDR);
        chk("rstwr_data", wrData, 32'd0);
        chk("rstwr_count", 32'(count), 32'd0);
        chk("rstwr_full", 32'(full), 32'd0);
        chk("rstwr_error", 32'(error), 32'd0);
        resetN = 1'b1;
        m_count = 0;
        m_error = 1'b0;
        @(negedge clk);
        chk("rstwr_ready_after", 32'(ready), 32'd1);
        chk("rstwr_no_strobe_after", 32'(wrEn), 32'd0);

        // Randomized requests against the reference model
        for (int i = 0; i < 80; i++) begin
            if (m_count == DEPTH || $urandom_range(0, 15) == 0) do_clear();
            v = rand_vec();
            do_req(v);
            chk("rand_error", 32'(error), 32'(m_error));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
